// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer between EX/MEM and the data-side memory port.
// One transaction at a time: IDLE -> REQ (valid/ready) -> WAIT (done or timeout).
module lsu_mem_sequencer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  input  logic        i_web,
  input  logic [1:0]  i_bweb_pre,
  input  logic [2:0]  i_funct3,
  input  logic        i_fp,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_mem_req,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_web,
  output logic [31:0] o_mem_bweb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_done,
  input  logic [31:0] i_mem_rdata,
  output logic        o_stall,
  output logic        o_ld_valid,
  output logic [31:0] o_ld_data,
  output logic        o_misalign,
  output logic        o_bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lat_size;
  logic [1:0]       lat_lane;
  logic             lat_uns;

  logic [1:0] eff_size;
  logic       misaligned;
  logic       req_ok;
  logic       accept;
  logic       timeout;
  logic       unused_funct3;

  function automatic logic [31:0] fmt_wdata(input logic [1:0] size, input logic [31:0] w);
    case (size)
      2'b01:   return {4{w[7:0]}};
      2'b10:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] fmt_bweb(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b01:   return ~(32'h0000_00FF << {lane, 3'b000});
      2'b10:   return ~(32'h0000_FFFF << {lane[1], 4'b0000});
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Halves and words are aligned here, so the byte-lane shift covers every size.
  function automatic logic [31:0] align_load(input logic [1:0] size, input logic uns,
                                             input logic [1:0] lane, input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {lane, 3'b000};
    case (size)
      2'b01:   return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b10:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign unused_funct3 = ^i_funct3[1:0];
  assign eff_size      = i_fp ? 2'b11 : i_bweb_pre;
  assign misaligned    = ((eff_size == 2'b10) && i_addr[0]) ||
                         ((eff_size == 2'b11) && (i_addr[1:0] != 2'b00));
  assign req_ok        = i_req_valid && (i_bweb_pre != 2'b00);
  assign accept        = (state == IDLE) && req_ok && !misaligned;
  assign timeout       = (cnt == CNT_LAST);
  assign o_stall       = accept || (state == REQ) ||
                         ((state == WAIT) && !i_mem_done && !timeout);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_size    <= 2'b00;
      lat_lane    <= 2'b00;
      lat_uns     <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_addr  <= 32'h0;
      o_mem_web   <= 1'b1;
      o_mem_bweb  <= 32'hFFFF_FFFF;
      o_mem_wdata <= 32'h0;
      o_ld_valid  <= 1'b0;
      o_ld_data   <= 32'h0;
      o_misalign  <= 1'b0;
      o_bus_err   <= 1'b0;
    end else begin
      o_ld_valid <= 1'b0;
      o_misalign <= 1'b0;
      o_bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            state       <= REQ;
            lat_size    <= eff_size;
            lat_lane    <= i_addr[1:0];
            lat_uns     <= i_funct3[2];
            o_mem_req   <= 1'b1;
            o_mem_addr  <= {i_addr[31:2], 2'b00};
            o_mem_web   <= i_web;
            o_mem_bweb  <= i_web ? 32'hFFFF_FFFF : fmt_bweb(eff_size, i_addr[1:0]);
            o_mem_wdata <= fmt_wdata(eff_size, i_wdata);
          end else if (req_ok) begin
            o_misalign <= 1'b1;
          end
        end
        REQ: begin
          if (i_mem_ready) begin
            state     <= WAIT;
            o_mem_req <= 1'b0;
            cnt       <= '0;
          end
        end
        WAIT: begin
          // Done wins over a timeout landing in the same cycle.
          if (i_mem_done) begin
            state <= IDLE;
            if (o_mem_web) begin
              o_ld_valid <= 1'b1;
              o_ld_data  <= align_load(lat_size, lat_uns, lat_lane, i_mem_rdata);
            end
          end else if (timeout) begin
            state     <= IDLE;
            o_bus_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Randomized self-checking bench for lsu_mem_sequencer against a byte-lane reference model.
module tb_lsu_mem_sequencer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        web = 1'b1;
  logic [1:0]  bweb_pre = 2'b00;
  logic [2:0]  funct3 = 3'b000;
  logic        fp = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        mem_req;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_web;
  logic [31:0] mem_bweb;
  logic [31:0] mem_wdata;
  logic        mem_done = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        misalign;
  logic        bus_err;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] last_ld = 32'h0;
  bit chained = 1'b0;

  lsu_mem_sequencer #(.TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_web(web),
    .i_bweb_pre(bweb_pre), .i_funct3(funct3), .i_fp(fp), .i_addr(addr), .i_wdata(wdata),
    .o_mem_req(mem_req), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr), .o_mem_web(mem_web),
    .o_mem_bweb(mem_bweb), .o_mem_wdata(mem_wdata), .i_mem_done(mem_done),
    .i_mem_rdata(mem_rdata), .o_stall(stall), .o_ld_valid(ld_valid), .o_ld_data(ld_data),
    .o_misalign(misalign), .o_bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic int m_size(input logic [1:0] pre, input logic f);
    if (f) return 4;
    return (pre == 2'b01) ? 1 : (pre == 2'b10) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_bweb(input int sz, input logic [31:0] a);
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
    if (sz == 4) return 32'h0;
    for (int b = 0; b < 4; b++)
      if (b >= (a % 4) && b < (a % 4) + sz) m[8*b +: 8] = 8'h00;
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] w);
    if (sz == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input int sz, input logic uns, input logic [31:0] a,
                                         input logic [31:0] r);
    logic [31:0] v;
    if (sz == 4) return r;
    v = (r >> (8 * (a % 4))) & ((sz == 1) ? 32'hFF : 32'hFFFF);
    if (!uns && v >= ((sz == 1) ? 32'h80 : 32'h8000))
      v = v | ((sz == 1) ? 32'hFFFF_FF00 : 32'hFFFF_0000);
    return v;
  endfunction

  task automatic run_txn(input logic w, input logic [1:0] pre, input logic [2:0] f3,
                         input logic f, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int rdy_dly, input int done_dly,
                         input bit chain_out);
    int sz;
    bit to;
    sz = m_size(pre, f);
    to = !(done_dly >= 0 && done_dly <= TO - 1);
    if (!chained) @(negedge clk);
    req_valid = 1'b1; web = w; bweb_pre = pre; funct3 = f3; fp = f; addr = a; wdata = wd;
    mem_ready = 1'b0; mem_done = 1'b0;
    #1;
    nvec++;
    if (stall !== 1'b1) begin nerr++; $display("FAIL accept_stall got %b want 1", stall); end
    for (int c = 0; c <= rdy_dly; c++) begin
      @(negedge clk);
      mem_ready = (c == rdy_dly);
      #1;
      nvec++;
      if ({mem_req, mem_web, mem_addr, mem_bweb, stall} !==
          {1'b1, w, a & 32'hFFFF_FFFC, w ? 32'hFFFF_FFFF : m_bweb(sz, a), 1'b1}) begin
        nerr++;
        $display("FAIL req_fields cyc%0d got req=%b web=%b addr=%h bweb=%h stall=%b want web=%b addr=%h bweb=%h",
                 c, mem_req, mem_web, mem_addr, mem_bweb, stall, w, a & 32'hFFFF_FFFC,
                 w ? 32'hFFFF_FFFF : m_bweb(sz, a));
      end
      if (!w) begin
        nvec++;
        if (mem_wdata !== m_wdata(sz, wd)) begin
          nerr++; $display("FAIL req_wdata got %h want %h", mem_wdata, m_wdata(sz, wd));
        end
      end
    end
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_done = (k == done_dly);
      mem_rdata = mem_done ? rd : $urandom;
      #1;
      nvec++;
      if ({mem_req, stall} !== {1'b0, !(mem_done || k == TO - 1)}) begin
        nerr++;
        $display("FAIL wait_stall k%0d got req=%b stall=%b want req=0 stall=%b",
                 k, mem_req, stall, !(mem_done || k == TO - 1));
      end
      if (mem_done) break;
    end
    @(negedge clk);
    mem_done = 1'b0;
    if (!chain_out) req_valid = 1'b0;
    #1;
    if (w && !to) last_ld = m_load(sz, f3[2], a, rd);
    nvec++;
    if ({ld_valid, bus_err, ld_data} !== {w && !to, to, last_ld}) begin
      nerr++;
      $display("FAIL complete got ld_valid=%b bus_err=%b ld_data=%h want %b %b %h",
               ld_valid, bus_err, ld_data, w && !to, to, last_ld);
    end
    chained = chain_out;
    if (!chain_out) begin
      nvec++;
      if (stall !== 1'b0) begin nerr++; $display("FAIL idle_stall got %b want 0", stall); end
      @(negedge clk);
      #1;
      nvec++;
      if ({ld_valid, bus_err, mem_req, ld_data} !== {3'b000, last_ld}) begin
        nerr++;
        $display("FAIL post_idle got ld_valid=%b bus_err=%b req=%b ld_data=%h want 0 0 0 %h",
                 ld_valid, bus_err, mem_req, ld_data, last_ld);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    nvec++;
    if ({mem_req, mem_web, mem_bweb, mem_addr, mem_wdata, stall, ld_valid, ld_data, misalign, bus_err}
        !== {1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_state got req=%b web=%b bweb=%h addr=%h wd=%h stall=%b ldv=%b ld=%h mis=%b err=%b",
               mem_req, mem_web, mem_bweb, mem_addr, mem_wdata, stall, ld_valid, ld_data, misalign, bus_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load_sign();
    run_txn(1'b1, 2'b01, 3'b000, 1'b0, 32'h0000_0103, 32'h0, 32'h8000_0000, 0, 0, 1'b0);
    run_txn(1'b1, 2'b01, 3'b100, 1'b0, 32'h0000_0103, 32'h0, 32'h8000_0000, 0, 0, 1'b0);
    run_txn(1'b1, 2'b10, 3'b001, 1'b0, 32'h0000_0102, 32'h0, 32'h8001_1234, 1, 2, 1'b0);
  endtask

  task automatic test_store_half();
    run_txn(1'b0, 2'b10, 3'b001, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 0, 0, 1'b0);
    run_txn(1'b0, 2'b01, 3'b000, 1'b0, 32'h0000_0201, 32'hDEAD_BE5A, 32'h0, 0, 1, 1'b0);
  endtask

  task automatic test_misalign();
    logic [1:0]  pres [4] = '{2'b11, 2'b10, 2'b01, 2'b11};
    logic        fps  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] adrs [4] = '{32'h301, 32'h201, 32'h102, 32'h303};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 1'b1; web = 1'b1; bweb_pre = pres[i]; fp = fps[i]; addr = adrs[i];
      #1;
      nvec++;
      if (stall !== 1'b0) begin nerr++; $display("FAIL mis_stall case%0d got %b want 0", i, stall); end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      nvec++;
      if ({misalign, mem_req, stall} !== 3'b100) begin
        nerr++; $display("FAIL mis_pulse case%0d got mis=%b req=%b stall=%b want 1 0 0", i, misalign, mem_req, stall);
      end
      @(negedge clk);
      #1;
      nvec++;
      if ({misalign, mem_req} !== 2'b00) begin
        nerr++; $display("FAIL mis_clear case%0d got mis=%b req=%b want 0 0", i, misalign, mem_req);
      end
    end
    fp = 1'b0;
  endtask

  task automatic test_ready_stall();
    run_txn(1'b0, 2'b11, 3'b010, 1'b0, 32'h0000_0500, 32'hCAFE_F00D, 32'h0, 5, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 2'b11, 3'b010, 1'b0, 32'h0000_0600, 32'h0, 32'h1111_2222, 0, -1, 1'b0);
    run_txn(1'b1, 2'b11, 3'b010, 1'b0, 32'h0000_0604, 32'h0, 32'h3333_4444, 2, TO - 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 2'b11, 3'b010, 1'b0, 32'h0000_0700, 32'h0BAD_F00D, 32'h0, 0, 0, 1'b1);
    run_txn(1'b1, 2'b01, 3'b000, 1'b0, 32'h0000_0702, 32'h0, 32'h0055_0000, 0, 0, 1'b1);
    run_txn(1'b1, 2'b11, 3'b010, 1'b1, 32'h0000_0708, 32'h0, 32'hA5A5_5A5A, 0, 0, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    req_valid = 1'b1; web = 1'b1; bweb_pre = 2'b11; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; rst_n = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    last_ld = 32'h0;
    nvec++;
    if ({mem_req, mem_web, mem_bweb, mem_addr, mem_wdata, stall, ld_valid, ld_data, misalign, bus_err}
        !== {1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL wait_reset got req=%b web=%b bweb=%h addr=%h wd=%h stall=%b ldv=%b ld=%h err=%b",
               mem_req, mem_web, mem_bweb, mem_addr, mem_wdata, stall, ld_valid, ld_data, bus_err);
    end
    run_txn(1'b1, 2'b11, 3'b010, 1'b0, 32'h0000_0404, 32'h0, 32'h7654_3210, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic        w;
      logic [1:0]  pre;
      logic        f;
      logic [31:0] a;
      int          sz;
      int          dd;
      w   = 1'($urandom);
      pre = 2'($urandom_range(1, 3));
      f   = ($urandom_range(0, 4) == 0);
      sz  = m_size(pre, f);
      a   = $urandom & ~(sz - 1);
      dd  = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, TO - 1);
      run_txn(w, pre, 3'($urandom), f, a, $urandom, $urandom, $urandom_range(0, 3), dd,
              (i != 39) && ($urandom_range(0, 2) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_load_sign();
    test_store_half();
    test_misalign();
    test_ready_stall();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", nvec);
    $fatal(1, "bench timeout");
  end

endmodule
